jtag_dpi_driver: RTL and testbench
==================================

// Module: jtag_dpi_driver
// PURPOSE
// - Bit-level JTAG master that turns host commands into TCK/TMS/TDI/TRST waveforms and returns the captured TDO bits.
// - Sits in the test bench between the host command source (DPI/TCP side) and the tap_top JTAG port.
// - TCK is derived from system_clk by a programmable divider.
// PARAMETERS
// - TCK_HALF_PERIOD  2  system_clk cycles per TCK half-period; legal range >=1.
// - TRST_CYCLES      4  system_clk cycles for which jtag_trst_o is held low by a TRST command.
// - PRINT_RECEIVED_JTAG_DATA  0  runtime trace enable; only effective with JTAG_DPI_PRINT_EN.
// PORTS
// - system_clk     in   1   clock; all logic on the rising edge.
// - reset          in   1   synchronous, active-high reset.
// - cmd_valid_i    in   1   command present.
// - cmd_ready_o    out  1   driver idle; a command is accepted when valid&ready.
// - cmd_op_i       in   2   0=SHIFT, 1=TRST pulse, 2=TLR (5x TMS=1), 3=NOP.
// - cmd_len_i      in   6   SHIFT bit count.
// - cmd_tms_i      in   32  per-bit TMS, LSB first.
// - cmd_tdi_i      in   32  per-bit TDI, LSB first.
// - rsp_valid_o    out  1   one-cycle pulse: command complete.
// - rsp_tdo_o      out  32  captured TDO, bit i = bit i shifted; held until the next response.
// - jtag_tck_o     out  1   JTAG clock.
// - jtag_tms_o     out  1   JTAG TMS.
// - jtag_tdi_o     out  1   JTAG TDI.
// - jtag_trst_o    out  1   JTAG TRST, active-low (1 = not in reset).
// - jtag_tdo_i     in   1   JTAG TDO from the TAP.
// BEHAVIOUR
// - Interface: one clock (system_clk); reset is synchronous and active-high.
// - Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_tdo_o=0, tck=0, tms=0, tdi=0, trst=1.
// - FSM states: IDLE, LOW, HIGH, TRST, RESP.
//   - IDLE: ready=1.
//   - On accept: ready drops the next cycle, and the command fields are latched.
// - SHIFT: per bit i, do both phases below.
//   - LOW phase: drive tms=cmd_tms[i] and tdi=cmd_tdi[i] with tck=0, for TCK_HALF_PERIOD cycles.
//   - HIGH phase: tck=1 for TCK_HALF_PERIOD cycles. jtag_tdo_i is sampled into tdo[i] on the cycle tck rises.
// - Bits shift LSB first. After the last HIGH phase, tck returns to 0 and rsp_valid_o pulses in that same cycle.
//   - Latency from accept to rsp_valid = len*2*TCK_HALF_PERIOD cycles.
//   - IDLE (ready=1) follows on the next cycle.
// - Length rules:
//   - cmd_len_i>32 saturates to 32.
//   - cmd_len_i=0: no TCK activity; rsp_valid pulses the cycle after accept with tdo=0.
//   - Unshifted tdo bits read 0.
// - TRST: trst=0 for TRST_CYCLES cycles, tck/tms stay 0, then trst=1. rsp_valid pulses with tdo=0 on the cycle trst returns high.
// - TLR: identical to SHIFT with len=5, tms=5'b11111, tdi=0. Its rsp_tdo carries the 5 captured bits.
// - NOP: rsp_valid pulses the cycle after accept with tdo=0.
// - tms/tdi keep their last driven values between commands.
// - cmd_valid while busy is ignored; the source holds it until ready.
// - Reset mid-command: abort immediately, all outputs return to reset values, and no response is produced.
// CONFIGURATION
// - Macro JTAG_DPI_PRINT_EN, defined:
//   - On each rsp_valid with PRINT_RECEIVED_JTAG_DATA!=0, $display "JTAG rx: len=<n> tdo=0x<hex>".
// - Macro JTAG_DPI_PRINT_EN, undefined:
//   - No trace code is compiled; the parameter is accepted and ignored.
//   - Waveforms are identical in both cases.
// TESTING (TCK_HALF_PERIOD=2, TRST_CYCLES=4)
// - Reset, then idle: ready=1, trst=1, tck=0, and rsp_valid never pulses.
// - TRST command: trst low for exactly 4 cycles, then rsp_valid with rsp_tdo=0.
// - TLR: 5 TCK pulses with tms=1, each tck high for 2 cycles; rsp_valid 20 cycles after accept.
// - Shift loopback (tdo_i tied to tdi_o): SHIFT len=8, tdi=0xA5, tms=0 -> rsp_tdo=0x000000A5, exactly 8 tck rises.
// - SHIFT len=32, tdi=0xDEADBEEF, TAP returning 0x12345678 LSB first -> rsp_tdo=0x12345678, rsp at 128 cycles.
// - Corner cases:
//   - len=0 -> rsp the next cycle, tdo=0.
//   - len=40 -> 32 bits shifted.
//   - Reset asserted at bit 3 of len=8 -> no rsp, and ready=1 once reset is released.

Source files
------------

// File: rtl/jtag_dpi_driver_if.sv
// jtag_dpi_driver_if: host command/response channel of the JTAG DPI driver
interface jtag_dpi_driver_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [5:0]  cmd_len_i;
  logic [31:0] cmd_tms_i;
  logic [31:0] cmd_tdi_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_tdo_o;
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_len_i, cmd_tms_i, cmd_tdi_i,
    input  cmd_ready_o, rsp_valid_o, rsp_tdo_o
  );
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_len_i, cmd_tms_i, cmd_tdi_i,
    output cmd_ready_o, rsp_valid_o, rsp_tdo_o
  );
endinterface

// File: rtl/jtag_dpi_driver.sv
// jtag_dpi_driver: bit-level JTAG master turning host commands into TCK/TMS/TDI/TRST; rx trace under JTAG_DPI_PRINT_EN
module jtag_dpi_driver #(
  parameter int TCK_HALF_PERIOD = 2,
  parameter int TRST_CYCLES = 4,
  parameter int PRINT_RECEIVED_JTAG_DATA = 0
) (
  input  logic system_clk,
  input  logic reset,
  jtag_dpi_driver_if.slave bus,
  output logic jtag_tck_o,
  output logic jtag_tms_o,
  output logic jtag_tdi_o,
  output logic jtag_trst_o,
  input  logic jtag_tdo_i
);
  localparam logic [1:0] OP_SHIFT = 2'd0, OP_TRST = 2'd1, OP_TLR = 2'd2;
  localparam int CMAX = TCK_HALF_PERIOD > TRST_CYCLES ? TCK_HALF_PERIOD : TRST_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, TRST, RESP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [5:0] len, req_len;
  logic [4:0] idx;
  logic [31:0] tms_q, tdi_q, tdo_q, rsp_tdo;
  logic tms_r, tdi_r, accept, half_done, trst_done, last_bit;
  assign accept = bus.cmd_valid_i && state == IDLE;
  assign half_done = cnt == CW'(TCK_HALF_PERIOD - 1);
  assign trst_done = cnt == CW'(TRST_CYCLES - 1);
  assign last_bit = {1'b0, idx} == len - 6'd1;
  assign req_len = bus.cmd_op_i == OP_TLR ? 6'd5 : bus.cmd_len_i > 6'd32 ? 6'd32 : bus.cmd_len_i;
  // state register
  always_ff @(posedge system_clk)
    state <= reset ? IDLE : nxt;
  // next-state: zero-length shifts and NOPs go straight to the response cycle
  always_comb
    nxt = state == IDLE ? (!accept ? IDLE :
                           bus.cmd_op_i == OP_TRST ? TRST :
                           (bus.cmd_op_i == OP_SHIFT || bus.cmd_op_i == OP_TLR) && req_len != 6'd0 ? LOW : RESP) :
          state == LOW  ? (half_done ? HIGH : LOW) :
          state == HIGH ? (half_done ? (last_bit ? RESP : LOW) : HIGH) :
          state == TRST ? (trst_done ? RESP : TRST) : IDLE;
  // command latch, phase counter, bit drive and TDO capture at each TCK rise
  always_ff @(posedge system_clk) begin
    if (reset) begin
      cnt <= '0;
      len <= '0;
      idx <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      tdo_q <= '0;
      tms_r <= 1'b0;
      tdi_r <= 1'b0;
      rsp_tdo <= '0;
    end else begin
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      if (accept) begin
        len <= bus.cmd_op_i == OP_SHIFT || bus.cmd_op_i == OP_TLR ? req_len : 6'd0;
        idx <= '0;
        tdo_q <= '0;
        tms_q <= bus.cmd_op_i == OP_TLR ? 32'h1f : bus.cmd_tms_i;
        tdi_q <= bus.cmd_op_i == OP_TLR ? 32'h0 : bus.cmd_tdi_i;
        if (nxt == LOW) begin
          tms_r <= bus.cmd_op_i == OP_TLR ? 1'b1 : bus.cmd_tms_i[0];
          tdi_r <= bus.cmd_op_i == OP_TLR ? 1'b0 : bus.cmd_tdi_i[0];
        end
        if (nxt == TRST) tms_r <= 1'b0;
      end
      if (state == LOW && nxt == HIGH) tdo_q[idx] <= jtag_tdo_i;
      if (state == HIGH && nxt == LOW) begin
        idx <= idx + 5'd1;
        tms_r <= tms_q[idx + 5'd1];
        tdi_r <= tdi_q[idx + 5'd1];
      end
      if (nxt == RESP && state != RESP) rsp_tdo <= state == HIGH ? tdo_q : 32'h0;
    end
  end
  // outputs decoded from state; tms/tdi hold their last value between commands
  always_comb begin
    bus.cmd_ready_o = state == IDLE;
    bus.rsp_valid_o = state == RESP;
    bus.rsp_tdo_o = rsp_tdo;
    jtag_tck_o = state == HIGH;
    jtag_trst_o = state != TRST;
    jtag_tms_o = tms_r;
    jtag_tdi_o = tdi_r;
  end
`ifdef JTAG_DPI_PRINT_EN
  // trace each completed command when enabled at runtime
  always_ff @(posedge system_clk)
    if (!reset && state == RESP && PRINT_RECEIVED_JTAG_DATA != 0)
      $display("JTAG rx: len=%0d tdo=0x%h", len, rsp_tdo);
`endif
endmodule

// File: tb/tb_jtag_dpi_driver.sv
// tb_jtag_dpi_driver: table-driven and randomized checks of jtag_dpi_driver against a spec-level model
module tb_jtag_dpi_driver;
  localparam int H = 2;
  localparam int TR = 4;
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] tms;
    logic [31:0] tdi;
    logic [31:0] pat;
    logic        loop;
    logic [31:0] exp_tdo;
    int          exp_lat;
    int          exp_rises;
  } vec_t;
  logic system_clk = 1'b0;
  logic reset = 1'b1;
  logic tck, tms, tdi, trst, tdo;
  logic loop = 1'b0;
  logic [31:0] pat = '0;
  logic hold_tms = 1'b0, hold_tdi = 1'b0;
  int rises = 0, base = 0, tck_hi = 0, tms_hi = 0, trst_lo = 0, rsp_cnt = 0;
  int checks = 0, errors = 0;
  vec_t tbl [10];
  jtag_dpi_driver_if bus ();
  jtag_dpi_driver #(.TCK_HALF_PERIOD(H), .TRST_CYCLES(TR), .PRINT_RECEIVED_JTAG_DATA(0)) dut (
    .system_clk(system_clk), .reset(reset), .bus(bus.slave),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_trst_o(trst), .jtag_tdo_i(tdo)
  );
  always #5 system_clk = ~system_clk;
  always @(posedge tck) rises++;
  assign tdo = loop ? tdi : (rises - base < 32 ? pat[5'(rises - base)] : 1'b0);
  always @(negedge system_clk) begin
    if (tck === 1'b1) tck_hi++;
    if (tck === 1'b1 && tms === 1'b1) tms_hi++;
    if (trst === 1'b0) trst_lo++;
    if (bus.rsp_valid_o === 1'b1) rsp_cnt++;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int n;
    logic [63:0] mask, src;
    n = v.op == 2 ? 5 : v.op == 0 ? (v.len > 32 ? 32 : int'(v.len)) : 0;
    mask = (64'd1 << n) - 64'd1;
    src = v.loop ? (v.op == 2 ? 64'd0 : {32'd0, v.tdi}) : {32'd0, v.pat};
    r.exp_rises = n;
    r.exp_lat = v.op == 1 ? TR : n * 2 * H;
    r.exp_tdo = 32'(src & mask);
    return r;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int n, lat, r0, h0, m0, tl0, c0, exp_mh;
    logic [31:0] teff, deff;
    n = v.exp_rises;
    teff = v.op == 2 ? 32'h1f : v.tms;
    deff = v.op == 2 ? 32'h0 : v.tdi;
    exp_mh = 0;
    for (int i = 0; i < n; i++) exp_mh += teff[i] ? H : 0;
    if (n > 0) begin
      hold_tms = teff[n-1];
      hold_tdi = deff[n-1];
    end
    if (v.op == 1) hold_tms = 1'b0;
    @(negedge system_clk);
    check({tag, " ready_idle"}, 64'(bus.cmd_ready_o), 64'd1);
    loop = v.loop;
    pat = v.pat;
    base = rises;
    r0 = rises; h0 = tck_hi; m0 = tms_hi; tl0 = trst_lo; c0 = rsp_cnt;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i = v.op;
    bus.cmd_len_i = v.len;
    bus.cmd_tms_i = v.tms;
    bus.cmd_tdi_i = v.tdi;
    @(negedge system_clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i = 2'd3;
    check({tag, " ready_busy"}, 64'(bus.cmd_ready_o), 64'd0);
    lat = 0;
    while (bus.rsp_valid_o !== 1'b1 && lat < 300) begin
      @(negedge system_clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " tdo"}, 64'(bus.rsp_tdo_o), 64'(v.exp_tdo));
    check({tag, " tck_rises"}, 64'(rises - r0), 64'(n));
    check({tag, " tck_high_cycles"}, 64'(tck_hi - h0), 64'(n * H));
    check({tag, " tms_at_tck_high"}, 64'(tms_hi - m0), 64'(exp_mh));
    check({tag, " trst_low_cycles"}, 64'(trst_lo - tl0), 64'(v.op == 1 ? TR : 0));
    @(negedge system_clk);
    check({tag, " rsp_pulses"}, 64'(rsp_cnt - c0), 64'd1);
    check({tag, " ready_back"}, 64'(bus.cmd_ready_o), 64'd1);
    check({tag, " tdo_held"}, 64'(bus.rsp_tdo_o), 64'(v.exp_tdo));
    check({tag, " tms_hold"}, 64'(tms), 64'(hold_tms));
    check({tag, " tdi_hold"}, 64'(tdi), 64'(hold_tdi));
  endtask
  initial begin
    int c0, wait_cyc;
    vec_t v;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i = 2'd3;
    bus.cmd_len_i = '0;
    bus.cmd_tms_i = '0;
    bus.cmd_tdi_i = '0;
    tbl[0] = '{2'd1, 6'd0,  32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        TR,  0};
    tbl[1] = '{2'd2, 6'd0,  32'h0,        32'h0,        32'h15,       1'b0, 32'h15,       20,  5};
    tbl[2] = '{2'd0, 6'd8,  32'h0,        32'ha5,       32'h0,        1'b1, 32'ha5,       32,  8};
    tbl[3] = '{2'd0, 6'd32, 32'h0,        32'hdeadbeef, 32'h12345678, 1'b0, 32'h12345678, 128, 32};
    tbl[4] = '{2'd0, 6'd0,  32'hffffffff, 32'hffffffff, 32'hffffffff, 1'b0, 32'h0,        0,   0};
    tbl[5] = '{2'd0, 6'd40, 32'h5,        32'hcafef00d, 32'h0,        1'b1, 32'hcafef00d, 128, 32};
    tbl[6] = '{2'd3, 6'd9,  32'hffffffff, 32'hffffffff, 32'hffffffff, 1'b0, 32'h0,        0,   0};
    tbl[7] = '{2'd2, 6'd0,  32'h0,        32'hffffffff, 32'h0,        1'b1, 32'h0,        20,  5};
    tbl[8] = '{2'd0, 6'd1,  32'h1,        32'h0,        32'h1,        1'b0, 32'h1,        4,   1};
    tbl[9] = '{2'd0, 6'd3,  32'h6,        32'h3,        32'hffffffff, 1'b0, 32'h7,        12,  3};
    repeat (3) @(negedge system_clk);
    check("reset ready", 64'(bus.cmd_ready_o), 64'd1);
    check("reset rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("reset rsp_tdo", 64'(bus.rsp_tdo_o), 64'd0);
    check("reset tck", 64'(tck), 64'd0);
    check("reset tms", 64'(tms), 64'd0);
    check("reset tdi", 64'(tdi), 64'd0);
    check("reset trst", 64'(trst), 64'd1);
    reset = 1'b0;
    c0 = rsp_cnt;
    repeat (10) @(negedge system_clk);
    check("idle no rsp", 64'(rsp_cnt - c0), 64'd0);
    check("idle ready", 64'(bus.cmd_ready_o), 64'd1);
    check("idle trst", 64'(trst), 64'd1);
    check("idle tck", 64'(tck), 64'd0);
    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));
    loop = 1'b1;
    base = rises;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i = 2'd0;
    bus.cmd_len_i = 6'd8;
    bus.cmd_tms_i = 32'hff;
    bus.cmd_tdi_i = 32'hff;
    @(negedge system_clk);
    bus.cmd_valid_i = 1'b0;
    wait_cyc = 0;
    while (rises - base < 4 && wait_cyc < 100) begin
      @(negedge system_clk);
      wait_cyc++;
    end
    check("midreset reached bit3", 64'(rises - base), 64'd4);
    reset = 1'b1;
    c0 = rsp_cnt;
    @(negedge system_clk);
    check("midreset tck", 64'(tck), 64'd0);
    check("midreset tms", 64'(tms), 64'd0);
    check("midreset tdi", 64'(tdi), 64'd0);
    check("midreset trst", 64'(trst), 64'd1);
    check("midreset rsp_tdo", 64'(bus.rsp_tdo_o), 64'd0);
    reset = 1'b0;
    hold_tms = 1'b0;
    hold_tdi = 1'b0;
    repeat (30) @(negedge system_clk);
    check("midreset no rsp", 64'(rsp_cnt - c0), 64'd0);
    check("midreset ready", 64'(bus.cmd_ready_o), 64'd1);
    check("midreset rises stop", 64'(rises - base), 64'd4);
    for (int i = 0; i < 25; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.len = 6'($urandom_range(0, 63));
      v.tms = $urandom;
      v.tdi = $urandom;
      v.pat = $urandom;
      v.loop = 1'($urandom_range(0, 1));
      run(model(v), $sformatf("rnd%0d op%0d len%0d", i, v.op, v.len));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
